// File: rtl/asic_pkg.sv
// Shared definitions for the command controller: function codes,
// FSM state encoding, default widths and command classification.
package asic_pkg;

  localparam int R_ADDR_DEF     = 4;
  localparam int FUNCT_BITS_DEF = 7;

  // Function codes, zero-extended to 32 bits for width-independent compares.
  localparam logic [31:0] F_SET   = 32'd0;
  localparam logic [31:0] F_LOAD  = 32'd1;
  localparam logic [31:0] F_STORE = 32'd2;
  localparam logic [31:0] F_ADD   = 32'd3;
  localparam logic [31:0] F_MUL   = 32'd4;
  localparam logic [31:0] F_SWS   = 32'd5;
  localparam logic [31:0] F_RELU  = 32'd6;
  localparam logic [31:0] F_INC   = 32'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RDOP  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MREQ  = 3'd3,
    ST_MWAIT = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    K_SET = 2'd0,
    K_MEM = 2'd1,
    K_ALU = 2'd2,
    K_BAD = 2'd3
  } cmd_kind_e;

  // Groups a function code by the path it takes through the FSM.
  function automatic cmd_kind_e classify(input logic [31:0] f);
    if (f == F_SET) return K_SET;
    else if (f == F_LOAD || f == F_STORE) return K_MEM;
    else if (f >= F_ADD && f <= F_INC) return K_ALU;
    else return K_BAD;
  endfunction

endpackage

// File: rtl/asic_cmd_latch.sv
// Holds the accepted command fields for the lifetime of the operation.
module asic_cmd_latch
  import asic_pkg::*;
#(
  parameter int FUNCT_BITS = FUNCT_BITS_DEF,
  parameter int R_ADDR     = R_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [FUNCT_BITS-1:0] funct_in,
  input  logic [R_ADDR-1:0]     rd_in,
  input  logic [R_ADDR-1:0]     rs0_in,
  input  logic [R_ADDR-1:0]     rs1_in,
  output logic [FUNCT_BITS-1:0] funct_q,
  output logic [R_ADDR-1:0]     rd_q,
  output logic [R_ADDR-1:0]     rs0_q,
  output logic [R_ADDR-1:0]     rs1_q
);

  logic [FUNCT_BITS-1:0] funct_d;
  logic [R_ADDR-1:0]     rd_d;
  logic [R_ADDR-1:0]     rs0_d;
  logic [R_ADDR-1:0]     rs1_d;

  // Load new command fields on enable, otherwise hold.
  always_comb begin
    funct_d = funct_q;
    rd_d    = rd_q;
    rs0_d   = rs0_q;
    rs1_d   = rs1_q;
    if (en) begin
      funct_d = funct_in;
      rd_d    = rd_in;
      rs0_d   = rs0_in;
      rs1_d   = rs1_in;
    end
  end

  // Command register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      funct_q <= '0;
      rd_q    <= '0;
      rs0_q   <= '0;
      rs1_q   <= '0;
    end else begin
      funct_q <= funct_d;
      rd_q    <= rd_d;
      rs0_q   <= rs0_d;
      rs1_q   <= rs1_d;
    end
  end

endmodule

// File: rtl/asic_ctrl.sv
// Command sequencer: accepts one processor command at a time, steers the
// register file, operand registers and write-bus drivers, issues memory
// requests for LOAD/STORE and reports completion.
//
// Handshakes (cmd, resp, mem_req): valid/ready. A transfer happens in the
// cycle where valid and ready are both 1; the sender holds valid (and its
// payload) until that cycle, and ready seen without valid means nothing.
module asic_ctrl
  import asic_pkg::*;
#(
  parameter int R_ADDR     = R_ADDR_DEF,
  parameter int FUNCT_BITS = FUNCT_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_val,
  output logic                  cmd_rdy,
  input  logic [FUNCT_BITS-1:0] cmd_funct,
  input  logic [R_ADDR-1:0]     cmd_rd,
  input  logic [R_ADDR-1:0]     cmd_rs0,
  input  logic [R_ADDR-1:0]     cmd_rs1,
  output logic                  resp_val,
  input  logic                  resp_rdy,
  output logic                  resp_err,
  output logic                  mem_req_val,
  input  logic                  mem_req_rdy,
  output logic                  mem_req_wr,
  input  logic                  mem_resp_val,
  output logic                  src_bus_en,
  output logic                  resp_bus_en,
  output logic                  add_bus_en,
  output logic                  mul_bus_en,
  output logic                  sws_bus_en,
  output logic                  relu_bus_en,
  output logic                  r_wen,
  output logic [R_ADDR-1:0]     r_waddr,
  output logic [R_ADDR-1:0]     r_raddr0,
  output logic [R_ADDR-1:0]     r_raddr1,
  output logic                  a_en,
  output logic                  b_en,
  output logic [1:0]            add_sel,
  output logic                  comp_sel,
  output logic                  busy,
  output state_e                dbg_state
);

  state_e state_q, state_d;

  logic [FUNCT_BITS-1:0] funct_q;
  logic [R_ADDR-1:0]     rd_q, rs0_q, rs1_q;
  logic                  accept;
  logic [31:0]           funct_ext;
  cmd_kind_e             in_kind, cur_kind;

  assign accept    = reset && (state_q == ST_IDLE) && cmd_val;
  assign funct_ext = 32'(funct_q);
  assign in_kind   = classify(32'(cmd_funct));
  assign cur_kind  = classify(funct_ext);
  assign dbg_state = state_q;

  asic_cmd_latch #(
    .FUNCT_BITS (FUNCT_BITS),
    .R_ADDR     (R_ADDR)
  ) u_cmd_latch (
    .clk      (clk),
    .reset    (reset),
    .en       (accept),
    .funct_in (cmd_funct),
    .rd_in    (cmd_rd),
    .rs0_in   (cmd_rs0),
    .rs1_in   (cmd_rs1),
    .funct_q  (funct_q),
    .rd_q     (rd_q),
    .rs0_q    (rs0_q),
    .rs1_q    (rs1_q)
  );

  // Next-state and output decode; everything stays 0 while reset is low.
  always_comb begin
    state_d     = state_q;
    cmd_rdy     = 1'b0;
    busy        = 1'b0;
    resp_val    = 1'b0;
    resp_err    = 1'b0;
    mem_req_val = 1'b0;
    mem_req_wr  = 1'b0;
    src_bus_en  = 1'b0;
    resp_bus_en = 1'b0;
    add_bus_en  = 1'b0;
    mul_bus_en  = 1'b0;
    sws_bus_en  = 1'b0;
    relu_bus_en = 1'b0;
    r_wen       = 1'b0;
    r_waddr     = '0;
    r_raddr0    = '0;
    r_raddr1    = '0;
    a_en        = 1'b0;
    b_en        = 1'b0;
    add_sel     = 2'd0;
    comp_sel    = 1'b0;
    if (reset) begin
      cmd_rdy  = (state_q == ST_IDLE);
      busy     = (state_q != ST_IDLE);
      // Reflects the last accepted command, so it changes only on accept.
      resp_err = (cur_kind == K_BAD);
      case (state_q)
        ST_IDLE: begin
          if (cmd_val) begin
            case (in_kind)
              K_SET: begin
                // SET writes the source bus straight away in the accept cycle.
                src_bus_en = 1'b1;
                r_wen      = 1'b1;
                r_waddr    = cmd_rd;
                state_d    = ST_RESP;
              end
              K_MEM:   state_d = ST_MREQ;
              K_ALU:   state_d = ST_RDOP;
              default: state_d = ST_RESP;
            endcase
          end
        end
        ST_RDOP: begin
          a_en     = 1'b1;
          b_en     = 1'b1;
          r_raddr0 = rs0_q;
          r_raddr1 = rs1_q;
          state_d  = ST_EXEC;
        end
        ST_EXEC: begin
          r_waddr = rd_q;
          case (funct_ext)
            F_ADD:  begin add_bus_en  = 1'b1; r_wen = 1'b1; end
            F_MUL:  begin mul_bus_en  = 1'b1; r_wen = 1'b1; end
            F_SWS:  begin sws_bus_en  = 1'b1; r_wen = 1'b1; end
            F_RELU: begin relu_bus_en = 1'b1; r_wen = 1'b1; end
            F_INC: begin
              add_bus_en = 1'b1;
              add_sel    = 2'd1;
              r_wen      = 1'b1;
            end
            default: r_wen = 1'b0;
          endcase
          state_d = ST_RESP;
        end
        ST_MREQ: begin
          // rs0 carries the address, rs1 the store data.
          mem_req_val = 1'b1;
          mem_req_wr  = (funct_ext == F_STORE);
          r_raddr0    = rs0_q;
          r_raddr1    = rs1_q;
          if (mem_req_rdy) state_d = ST_MWAIT;
        end
        ST_MWAIT: begin
          if (mem_resp_val) begin
            if (funct_ext == F_LOAD) begin
              resp_bus_en = 1'b1;
              r_wen       = 1'b1;
              r_waddr     = rd_q;
            end
            state_d = ST_RESP;
          end
        end
        ST_RESP: begin
          resp_val = 1'b1;
          if (resp_rdy) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_asic_ctrl.sv
// Bench for asic_ctrl: each command is expanded into its expected
// cycle-by-cycle output trace from the command's rules and the chosen
// handshake delays, then compared with the DUT every cycle.
module tb_asic_ctrl;
  import asic_pkg::*;

  localparam int RA = 4;
  localparam int FB = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_val, cmd_rdy;
  logic [FB-1:0] cmd_funct;
  logic [RA-1:0] cmd_rd, cmd_rs0, cmd_rs1;
  logic          resp_val, resp_rdy, resp_err;
  logic          mem_req_val, mem_req_rdy, mem_req_wr, mem_resp_val;
  logic          src_bus_en, resp_bus_en, add_bus_en, mul_bus_en, sws_bus_en, relu_bus_en;
  logic          r_wen;
  logic [RA-1:0] r_waddr, r_raddr0, r_raddr1;
  logic          a_en, b_en, comp_sel, busy;
  logic [1:0]    add_sel;
  state_e        dbg_state;

  asic_ctrl #(.R_ADDR(RA), .FUNCT_BITS(FB)) dut (
    .clk(clk), .reset(reset),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_funct(cmd_funct),
    .cmd_rd(cmd_rd), .cmd_rs0(cmd_rs0), .cmd_rs1(cmd_rs1),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_err(resp_err),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_wr(mem_req_wr),
    .mem_resp_val(mem_resp_val),
    .src_bus_en(src_bus_en), .resp_bus_en(resp_bus_en), .add_bus_en(add_bus_en),
    .mul_bus_en(mul_bus_en), .sws_bus_en(sws_bus_en), .relu_bus_en(relu_bus_en),
    .r_wen(r_wen), .r_waddr(r_waddr), .r_raddr0(r_raddr0), .r_raddr1(r_raddr1),
    .a_en(a_en), .b_en(b_en), .add_sel(add_sel), .comp_sel(comp_sel),
    .busy(busy), .dbg_state(dbg_state)
  );

  // bus = {src, resp, add, mul, sws, relu}
  typedef struct packed {
    logic          cmd_rdy;
    logic          busy;
    logic          resp_val;
    logic          resp_err;
    logic          mem_req_val;
    logic          mem_req_wr;
    logic [5:0]    bus;
    logic          r_wen;
    logic [RA-1:0] waddr;
    logic [RA-1:0] raddr0;
    logic [RA-1:0] raddr1;
    logic          a_en;
    logic          b_en;
    logic [1:0]    add_sel;
    logic          comp_sel;
  } obs_t;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.cmd_rdy     = cmd_rdy;
    o.busy        = busy;
    o.resp_val    = resp_val;
    o.resp_err    = resp_err;
    o.mem_req_val = mem_req_val;
    o.mem_req_wr  = mem_req_wr;
    o.bus         = {src_bus_en, resp_bus_en, add_bus_en, mul_bus_en, sws_bus_en, relu_bus_en};
    o.r_wen       = r_wen;
    o.waddr       = r_waddr;
    o.raddr0      = r_raddr0;
    o.raddr1      = r_raddr1;
    o.a_en        = a_en;
    o.b_en        = b_en;
    o.add_sel     = add_sel;
    o.comp_sel    = comp_sel;
    return o;
  endfunction

  function automatic obs_t idle_exp();
    obs_t e = '0;
    e.cmd_rdy = 1'b1;
    return e;
  endfunction

  function automatic obs_t busy_exp();
    obs_t e = '0;
    e.busy = 1'b1;
    return e;
  endfunction

  // Addresses, resp_err and mem_req_wr only matter where they are defined.
  function automatic obs_t base_care();
    obs_t c = '1;
    c.waddr      = '0;
    c.raddr0     = '0;
    c.raddr1     = '0;
    c.resp_err   = 1'b0;
    c.mem_req_wr = 1'b0;
    return c;
  endfunction

  // One clock: compare outputs at the falling edge, then advance past the rise.
  task automatic cycle(input string tag, input obs_t e, input obs_t c, input int st);
    obs_t got;
    @(negedge clk);
    got = sample();
    check(tag, 32'(got & c), 32'(e & c));
    check({tag, ":bus_onehot"}, 32'($countones(got.bus) <= 1), 32'd1);
    check({tag, ":wen_bus"}, 32'(got.r_wen && ($countones(got.bus) != 1)), 32'd0);
    check({tag, ":rdy_busy"}, 32'(got.cmd_rdy && got.busy), 32'd0);
    if (st >= 0) check({tag, ":state"}, 32'(dbg_state), 32'(st));
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic scramble();
    cmd_val      = 1'($urandom_range(0, 1));
    cmd_funct    = FB'($urandom);
    cmd_rd       = RA'($urandom);
    cmd_rs0      = RA'($urandom);
    cmd_rs1      = RA'($urandom);
    mem_req_rdy  = 1'($urandom_range(0, 1));
    mem_resp_val = 1'($urandom_range(0, 1));
    resp_rdy     = 1'($urandom_range(0, 1));
  endtask

  // Issue one command (DUT must be idle) and check its whole trace.
  task automatic run_cmd(input int f, input int rd, input int rs0, input int rs1,
                         input int req_dly, input int resp_dly, input int rdy_dly,
                         input int gap);
    obs_t e, c;
    int   kind;  // 0 SET, 1 LOAD/STORE, 2 ALU op, 3 unsupported
    kind = (f == 0) ? 0 : (f == 1 || f == 2) ? 1 : (f >= 3 && f <= 7) ? 2 : 3;

    scramble();
    cmd_val   = 1'b1;
    cmd_funct = FB'(f);
    cmd_rd    = RA'(rd);
    cmd_rs0   = RA'(rs0);
    cmd_rs1   = RA'(rs1);
    e = idle_exp();
    c = base_care();
    if (kind == 0) begin
      e.bus   = 6'b100000;
      e.r_wen = 1'b1;
      e.waddr = RA'(rd);
      c.waddr = '1;
    end
    cycle($sformatf("accept_f%0d", f), e, c, 32'(ST_IDLE));

    if (kind == 2) begin
      scramble();
      e = busy_exp(); c = base_care();
      e.a_en = 1'b1; e.b_en = 1'b1;
      e.raddr0 = RA'(rs0); e.raddr1 = RA'(rs1);
      c.raddr0 = '1; c.raddr1 = '1;
      cycle($sformatf("rdop_f%0d", f), e, c, -1);
      scramble();
      e = busy_exp(); c = base_care();
      case (f)
        3: e.bus = 6'b001000;
        4: e.bus = 6'b000100;
        5: e.bus = 6'b000010;
        6: e.bus = 6'b000001;
        default: begin e.bus = 6'b001000; e.add_sel = 2'd1; end
      endcase
      e.r_wen = 1'b1;
      e.waddr = RA'(rd);
      c.waddr = '1;
      cycle($sformatf("exec_f%0d", f), e, c, -1);
    end

    if (kind == 1) begin
      for (int i = 0; i <= req_dly; i++) begin
        scramble();
        mem_req_rdy = (i == req_dly);
        if (i == req_dly) mem_resp_val = 1'b1;  // must not count as the response
        e = busy_exp(); c = base_care();
        e.mem_req_val = 1'b1;
        e.mem_req_wr  = (f == 2);
        e.raddr0 = RA'(rs0); e.raddr1 = RA'(rs1);
        c.mem_req_wr = 1'b1; c.raddr0 = '1; c.raddr1 = '1;
        cycle($sformatf("mreq_f%0d_%0d", f, i), e, c, -1);
      end
      for (int j = 0; j <= resp_dly; j++) begin
        scramble();
        mem_resp_val = (j == resp_dly);
        e = busy_exp(); c = base_care();
        if (j == resp_dly && f == 1) begin
          e.bus   = 6'b010000;
          e.r_wen = 1'b1;
          e.waddr = RA'(rd);
          c.waddr = '1;
        end
        cycle($sformatf("mwait_f%0d_%0d", f, j), e, c, -1);
      end
    end

    for (int k = 0; k <= rdy_dly; k++) begin
      scramble();
      resp_rdy = (k == rdy_dly);
      e = busy_exp(); c = base_care();
      e.resp_val = 1'b1;
      e.resp_err = (kind == 3);
      c.resp_err = 1'b1;
      cycle($sformatf("resp_f%0d_%0d", f, k), e, c, 32'(ST_RESP));
    end

    for (int g = 0; g < gap; g++) begin
      scramble();
      cmd_val = 1'b0;
      cycle("gap", idle_exp(), base_care(), 32'(ST_IDLE));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    obs_t zero_care;
    zero_care = '1;

    cmd_val = 1'b1; cmd_funct = '0; cmd_rd = 4'd3; cmd_rs0 = '0; cmd_rs1 = '0;
    resp_rdy = 1'b0; mem_req_rdy = 1'b0; mem_resp_val = 1'b0;

    // Reset held with a SET pending: nothing may respond.
    #12;
    check("reset_outputs", 32'(sample() & zero_care), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    cmd_val = 1'b0;
    reset   = 1'b1;
    cycle("post_reset_idle", idle_exp(), base_care(), 32'(ST_IDLE));

    // Directed commands: f, rd, rs0, rs1, req_dly, resp_dly, rdy_dly, gap
    run_cmd(0,   3, 0, 1, 0, 0, 0, 1);  // SET
    run_cmd(3,   5, 1, 2, 0, 0, 0, 0);  // ADD
    run_cmd(1,   7, 4, 9, 4, 2, 0, 1);  // LOAD with slow memory
    run_cmd(2,   2, 6, 8, 1, 0, 1, 0);  // STORE
    run_cmd(4,   9, 3, 3, 0, 0, 0, 0);  // MUL
    run_cmd(5,  10, 2, 1, 0, 0, 0, 0);  // SWS
    run_cmd(6,  11, 5, 0, 0, 0, 0, 0);  // RELU
    run_cmd(7,  12, 0, 6, 0, 0, 2, 1);  // INC
    run_cmd(9,   1, 1, 1, 0, 0, 3, 0);  // unsupported, slow resp_rdy
    run_cmd(127, 4, 2, 2, 0, 0, 0, 0);  // unsupported, max code
    run_cmd(0,  15, 0, 0, 0, 0, 0, 0);  // SET right after an error

    // Reset while waiting on memory, then a late response.
    scramble();
    cmd_val = 1'b1; cmd_funct = 7'd1; cmd_rd = 4'd6; cmd_rs0 = 4'd2; cmd_rs1 = 4'd3;
    mem_req_rdy = 1'b0;
    @(posedge clk); #1;
    cmd_val = 1'b0; mem_req_rdy = 1'b1; mem_resp_val = 1'b0;
    @(posedge clk); #1;
    mem_req_rdy = 1'b0; mem_resp_val = 1'b0; resp_rdy = 1'b0;
    @(negedge clk);
    check("abort_in_mwait", 32'(dbg_state), 32'(ST_MWAIT));
    #1 reset = 1'b0;
    #1;
    check("abort_outputs", 32'(sample() & zero_care), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    reset = 1'b1; mem_resp_val = 1'b1;
    cycle("late_resp_0", idle_exp(), base_care(), 32'(ST_IDLE));
    cycle("late_resp_1", idle_exp(), base_care(), 32'(ST_IDLE));
    mem_resp_val = 1'b0;

    // Random command stream.
    for (int n = 0; n < 60; n++) begin
      int f;
      f = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 11));
      run_cmd(f, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
